// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: rotates a one-cold row drive, debounces a single
// key press/release, and presents a registered calculator key code.
module keypad_scan #(
   parameter int SCAN_DIV = 1000,
   parameter int DEBOUNCE = 20000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] col,
   output logic [3:0] row,
   output logic [7:0] code,
   output logic       pressed
);
   localparam int DW = $clog2(SCAN_DIV);
   localparam int BW = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE - 1);

   typedef enum logic [3:0] {
      SCAN    = 4'b0001,
      DEBNC   = 4'b0010,
      HELD    = 4'b0100,
      RELEASE = 4'b1000
   } state_t;

   state_t        state;
   logic [3:0]    s1, scol, lpat;
   logic [1:0]    ridx;
   logic [DW-1:0] dwell;
   logic [BW-1:0] dcnt;
   logic [3:0]    low;
   logic          one_low;

   // Exactly one column pulled low; two or more low is a multi-key and ignored.
   assign low     = ~scol;
   assign one_low = (low != 4'h0) && ((low & (low - 4'd1)) == 4'h0);

   function automatic logic [7:0] key_code(input logic [1:0] r, input logic [3:0] p);
      logic [1:0] c;
      logic [7:0] k;
      c = !p[0] ? 2'd0 : !p[1] ? 2'd1 : !p[2] ? 2'd2 : 2'd3;
      case ({r, c})
         4'd0:  k = 8'h01;
         4'd1:  k = 8'h02;
         4'd2:  k = 8'h03;
         4'd3:  k = 8'hF1;
         4'd4:  k = 8'h04;
         4'd5:  k = 8'h05;
         4'd6:  k = 8'h06;
         4'd7:  k = 8'hF2;
         4'd8:  k = 8'h07;
         4'd9:  k = 8'h08;
         4'd10: k = 8'h09;
         4'd11: k = 8'hF3;
         4'd12: k = 8'hCC;
         4'd13: k = 8'h00;
         4'd14: k = 8'hEE;
         default: k = 8'hF4;
      endcase
      return k;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1      <= 4'hF;
         scol    <= 4'hF;
         lpat    <= 4'hF;
         state   <= SCAN;
         row     <= 4'b1110;
         ridx    <= 2'd0;
         dwell   <= '0;
         dcnt    <= '0;
         code    <= 8'hFF;
         pressed <= 1'b0;
      end else begin
         s1   <= col;
         scol <= s1;
         unique case (state)
            SCAN: begin
               if (dwell == DWELL_LAST) begin
                  dwell <= '0;
                  if (one_low) begin
                     lpat  <= scol;
                     dcnt  <= '0;
                     state <= DEBNC;
                  end else begin
                     row  <= {row[2:0], row[3]};
                     ridx <= ridx + 2'd1;
                  end
               end else begin
                  dwell <= dwell + DW'(1);
               end
            end
            DEBNC: begin
               if (scol == lpat) begin
                  if (dcnt == DEB_LAST) begin
                     state   <= HELD;
                     pressed <= 1'b1;
                     code    <= key_code(ridx, lpat);
                  end else begin
                     dcnt <= dcnt + BW'(1);
                  end
               end else begin
                  // Bounce: abandon this candidate and carry on from the next row.
                  state <= SCAN;
                  dwell <= '0;
                  row   <= {row[2:0], row[3]};
                  ridx  <= ridx + 2'd1;
               end
            end
            HELD: begin
               if (scol == 4'hF) begin
                  state <= RELEASE;
                  dcnt  <= '0;
               end
            end
            RELEASE: begin
               if (scol == 4'hF) begin
                  if (dcnt == DEB_LAST) begin
                     state   <= SCAN;
                     pressed <= 1'b0;
                     code    <= 8'hFF;
                     dwell   <= '0;
                     row     <= {row[2:0], row[3]};
                     ridx    <= ridx + 2'd1;
                  end else begin
                     dcnt <= dcnt + BW'(1);
                  end
               end else begin
                  state <= HELD;
               end
            end
            default: state <= SCAN;
         endcase
      end
   end
endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: keypad matrix model, per-key table, corner-case
// sequences, and a queue of expected codes checked on each pressed rise.
module tb_keypad_scan;
   localparam int SCAN_DIV = 4;
   localparam int DEBOUNCE = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] col, row;
   logic [7:0] code;
   logic       pressed;

   logic [15:0] keys = '0;
   logic        glitch = 1'b0;
   logic        mon_en = 1'b0;
   logic        prev_p = 1'b0;
   int          errors = 0;
   int          checks = 0;
   logic [7:0]  expq[$];

   typedef struct {
      int         r;
      int         c;
      logic [7:0] kc;
   } vec_t;
   vec_t vt[16];

   keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
      .clk(clk), .rst(rst), .col(col), .row(row), .code(code), .pressed(pressed)
   );

   always #5 clk = ~clk;

   // Passive matrix: a held key shorts its column to its row when that row is driven low.
   always_comb begin
      col = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!row[r] && keys[r*4+c]) col[c] = 1'b0;
      if (glitch) col = 4'hF;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         chk("row_one_cold", 32'($countones(~row)), 32'd1);
         if (!pressed) chk("idle_code", {24'h0, code}, 32'hFF);
         if (pressed && !prev_p) begin
            if (expq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_press: got code %0h expected no press", code);
            end else begin
               chk("press_code", {24'h0, code}, {24'h0, expq.pop_front()});
            end
         end
         if (!pressed && prev_p) chk("release_code", {24'h0, code}, 32'hFF);
         prev_p <= pressed;
      end
   end

   task automatic wait_p(input logic val, input int budget, input string name);
      int n = 0;
      while (pressed !== val && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(name, {31'h0, pressed}, {31'h0, val});
   endtask

   task automatic wait_row(input logic [3:0] val, input int budget);
      int n = 0;
      while (row !== val && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("wait_row", {28'h0, row}, {28'h0, val});
   endtask

   function automatic logic [3:0] cold(input int r);
      logic [3:0] v;
      v = 4'hF;
      v[r] = 1'b0;
      return v;
   endfunction

   initial begin
      int n;
      logic [7:0] codes[16];
      codes = '{8'h01, 8'h02, 8'h03, 8'hF1, 8'h04, 8'h05, 8'h06, 8'hF2,
                8'h07, 8'h08, 8'h09, 8'hF3, 8'hCC, 8'h00, 8'hEE, 8'hF4};
      for (int i = 0; i < 16; i++) vt[i] = '{i / 4, i % 4, codes[i]};

      // Reset state and free-running scan
      repeat (3) @(negedge clk);
      chk("reset_row", {28'h0, row}, 32'hE);
      chk("reset_code", {24'h0, code}, 32'hFF);
      chk("reset_pressed", {31'h0, pressed}, 32'h0);
      rst = 1'b0;
      mon_en = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         chk("scan_row", {23'h0, pressed, code, row}, {23'h0, 1'b0, 8'hFF, cold(((i + 1) / 4) % 4)});
      end

      // Every key once: freeze on its row, hold, release resumes at the next row
      for (int i = 0; i < 16; i++) begin
         keys = '0;
         keys[vt[i].r*4+vt[i].c] = 1'b1;
         expq.push_back(vt[i].kc);
         wait_p(1'b1, 100, "tbl_press");
         chk("tbl_frozen_row", {28'h0, row}, {28'h0, cold(vt[i].r)});
         repeat (5) @(negedge clk);
         chk("tbl_still_held", {31'h0, pressed}, 32'h1);
         keys = '0;
         wait_p(1'b0, 100, "tbl_release");
         chk("tbl_next_row", {28'h0, row}, {28'h0, cold((vt[i].r + 1) % 4)});
         repeat (3) @(negedge clk);
      end

      // r1c1: exact press latency, second key ignored while held, exact release latency
      keys = '0;
      keys[5] = 1'b1;
      expq.push_back(8'h05);
      wait_row(4'b1110, 40);
      wait_row(4'b1101, 40);
      n = 0;
      while (!pressed && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("press_latency", n, SCAN_DIV + DEBOUNCE);
      keys[6] = 1'b1;
      repeat (20) @(negedge clk);
      chk("held_ignore", {20'h0, pressed, code, row}, {20'h0, 1'b1, 8'h05, 4'b1101});
      keys[6] = 1'b0;
      repeat (4) @(negedge clk);
      keys = '0;
      n = 0;
      while (pressed && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("release_latency", n, 3 + DEBOUNCE);
      chk("resume_row", {28'h0, row}, 32'hB);

      // r3c2 with a 2-clock open glitch inside debounce: one press, code EE
      repeat (5) @(negedge clk);
      keys = '0;
      keys[14] = 1'b1;
      expq.push_back(8'hEE);
      wait_row(4'b0111, 40);
      repeat (5) @(negedge clk);
      glitch = 1'b1;
      repeat (2) @(negedge clk);
      glitch = 1'b0;
      chk("glitch_no_press", {31'h0, pressed}, 32'h0);
      wait_p(1'b1, 100, "glitch_press");
      repeat (10) @(negedge clk);
      keys = '0;
      wait_p(1'b0, 100, "glitch_release");

      // Two keys on row 0 is a multi-key; dropping c3 leaves a valid '1'
      keys = '0;
      keys[0] = 1'b1;
      keys[3] = 1'b1;
      repeat (60) @(negedge clk);
      chk("multikey_no_press", {31'h0, pressed}, 32'h0);
      expq.push_back(8'h01);
      keys[3] = 1'b0;
      wait_p(1'b1, 100, "multikey_press");
      keys = '0;
      wait_p(1'b0, 100, "multikey_release");

      // Reset while holding '*': immediate idle outputs, then a fresh debounce
      repeat (3) @(negedge clk);
      keys = '0;
      keys[11] = 1'b1;
      expq.push_back(8'hF3);
      wait_p(1'b1, 100, "rst_press");
      repeat (4) @(negedge clk);
      rst = 1'b1;
      expq.push_back(8'hF3);
      #1;
      chk("rst_async", {19'h0, pressed, code, row}, {19'h0, 1'b0, 8'hFF, 4'b1110});
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_no_repress", {31'h0, pressed}, 32'h0);
      wait_p(1'b1, 100, "rst_repress");
      keys = '0;
      wait_p(1'b0, 100, "rst_release");
      repeat (5) @(negedge clk);
      chk("queue_empty", expq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
